ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the CPU to the keyboard over the same open-collector ps2_clk/ps2_data lines that the keyboard receiver samples. It implements inhibit, request-to-send, 11-bit frame shifting on device-generated clock edges, the acknowledge check and a timeout. The pads are driven only through pull-low enables. The top level turns each enable into a tri-state that drives 0 or high-Z.

---
 rtl/ps2_host_tx_pkg.sv | 22 ++
 rtl/ps2_host_tx_if.sv | 15 +
 rtl/ps2_edge_sync.sv | 40 ++++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line synchroniser.
package ps2_pkg;

  localparam int         FRAME_DATA_BITS = 8;
  localparam int         TX_SHIFT_BITS   = 10;   // d0..d7, parity, stop
  localparam logic [3:0] FALL_PATTERN    = 4'b1100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SEND      = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4,
    FINISH    = 3'd5
  } state_e;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [TX_SHIFT_BITS-1:0] tx_frame(input logic [FRAME_DATA_BITS-1:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// CPU-side write port of the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [FRAME_DATA_BITS-1:0] din;
  logic                       wrn;
  logic                       busy;
  logic                       done;
  logic                       ack_err;
  logic                       overflow;

  modport master (output din, wrn, input busy, done, ack_err, overflow);
  modport slave  (input din, wrn, output busy, done, ack_err, overflow);

endinterface

// File: rtl/ps2_edge_sync.sv
// Synchronises the PS/2 clock and data pads and flags device clock falling edges.
// The clock path is four deep so a falling edge is only reported after two
// stable high samples followed by two stable low samples.
module ps2_edge_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fe
);

  logic [3:0] clk_sh_q, clk_sh_d;
  logic [1:0] data_sh_q, data_sh_d;

  // Shift new pad samples in at the LSB; the MSB is the oldest sample.
  always_comb begin
    clk_sh_d  = {clk_sh_q[2:0], ps2_clk_in};
    data_sh_d = {data_sh_q[0], ps2_data_in};
  end

  // Synchroniser flops; reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (clr) begin
      clk_sh_q  <= '1;
      data_sh_q <= '1;
    end else begin
      clk_sh_q  <= clk_sh_d;
      data_sh_q <= data_sh_d;
    end
  end

  assign clk_sync  = clk_sh_q[1];
  assign data_sync = data_sh_q[1];
  assign fe        = (clk_sh_q == FALL_PATTERN);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. The pads are open drain: this block
// only produces pull-low enables, the pad ring turns each one into 0 / high-Z.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | lines released, waiting for a write
//   INHIBIT   | ps2_clk pulled low; start bit asserted on the last cycle
//   SEND      | ps2_clk released; next bit put on data at each device fall
//   ACK       | stop bit out; sample the device acknowledge on the next fall
//   WAIT_IDLE | wait for both synced lines high
//   FINISH    | done pulse, busy drops on exit
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          clr,
  ps2_host_tx_if.slave  cpu,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                   state_q, state_d;
  logic [TX_SHIFT_BITS-1:0] shift_q, shift_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     clk_oe_q, clk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ack_err_q, ack_err_d;
  logic                     overflow_q, overflow_d;

  logic clk_sync, data_sync, fe;
  logic wr_req, inhibit_end, timeout, last_bit, line_idle;

  ps2_edge_sync u_sync (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .fe          (fe)
  );

  assign wr_req      = ~cpu.wrn;
  assign inhibit_end = (cnt_q == CNT_W'(INHIBIT_CYCLES - 1));
  // A device edge in the same cycle as the limit wins: the counter restarts.
  assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !fe;
  assign last_bit    = (bit_cnt_q == 4'(TX_SHIFT_BITS - 1));
  assign line_idle   = clk_sync && data_sync;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (wr_req) state_d = INHIBIT;
      INHIBIT:   if (inhibit_end) state_d = SEND;
      SEND:      if (fe && last_bit) state_d = ACK;
                 else if (timeout) state_d = FINISH;
      ACK:       if (fe) state_d = WAIT_IDLE;
                 else if (timeout) state_d = FINISH;
      WAIT_IDLE: if (line_idle || timeout) state_d = FINISH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Line enables, shifter, timer and status flags.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    ack_err_d  = ack_err_q;
    overflow_d = overflow_q;
    done_d     = (state_d == FINISH) && (state_q != FINISH);

    if (wr_req && state_q != IDLE) overflow_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (wr_req) begin
          shift_d    = tx_frame(cpu.din);
          bit_cnt_d  = '0;
          cnt_d      = '0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
          ack_err_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      INHIBIT: begin
        if (inhibit_end) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        // Clock is released one cycle after the start bit goes down.
        clk_oe_d = 1'b0;
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = '0;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          ack_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        if (fe) begin
          ack_err_d = data_sync;
          cnt_d     = '0;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          ack_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (fe) begin
          cnt_d = '0;
        end else if (line_idle) begin
          cnt_d = '0;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          ack_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign cpu.busy     = busy_q;
  assign cpu.done     = done_q;
  assign cpu.ack_err  = ack_err_q;
  assign cpu.overflow = overflow_q;

endmodule
